mult_acc_pipe: RTL and testbench

Parametrised three-stage pipelined multiplier / multiply-accumulator. Successor to the registered two-operand product block, generalised in operand/result width and signedness. Adds a valid qualifier, a per-sample multiply/accumulate mode, an accumulator clear and a sticky overflow flag. Used wherever a streamed A*B product or running sum of products is needed in the datapath.

---
 rtl/mult_acc_pipe.sv | 135 +++++++++++++
 tb/tb_mult_acc_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_acc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_acc_pipe: three-stage pipelined multiplier / multiply-accumulator      |
// |   with valid qualifier, accumulator clear and sticky overflow flag.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mult_acc_pipe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] q,
  output logic                 overflow
);

  localparam int c_PROD_W = 2 * WIDTH;

  if (WIDTH < 2) begin : g_bad_width
    $error("mult_acc_pipe: WIDTH must be >= 2");
  end
  if (ACC_WIDTH < c_PROD_W) begin : g_bad_acc_width
    $error("mult_acc_pipe: ACC_WIDTH must be >= 2*WIDTH");
  end

  // Stage 1: input registers
  logic [WIDTH-1:0] a1_q, b1_q;
  logic             vld1_q, mode1_q, clr1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1_q    <= '0;
      b1_q    <= '0;
      vld1_q  <= 1'b0;
      mode1_q <= 1'b0;
      clr1_q  <= 1'b0;
    end else begin
      a1_q    <= a;
      b1_q    <= b;
      vld1_q  <= in_valid;
      mode1_q <= mode;
      clr1_q  <= acc_clr;
    end
  end

  // Stage 2: full-width product of the registered operands
  logic [c_PROD_W-1:0] prod_d, prod_q;
  logic                vld2_q, mode2_q, clr2_q;

  if (SIGNED != 0) begin : g_smul
    logic signed [c_PROD_W-1:0] w_sa, w_sb;
    assign w_sa   = {{WIDTH{a1_q[WIDTH-1]}}, a1_q};
    assign w_sb   = {{WIDTH{b1_q[WIDTH-1]}}, b1_q};
    assign prod_d = w_sa * w_sb;
  end else begin : g_umul
    assign prod_d = {{WIDTH{1'b0}}, a1_q} * {{WIDTH{1'b0}}, b1_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q  <= '0;
      vld2_q  <= 1'b0;
      mode2_q <= 1'b0;
      clr2_q  <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      vld2_q  <= vld1_q;
      mode2_q <= mode1_q;
      clr2_q  <= clr1_q;
    end
  end

  // Stage 3: extend product, then load or accumulate into q
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_add_ovf;
  logic [ACC_WIDTH-1:0] q_d, q_q;
  logic                 ovf_d, ovf_q, out_valid_q;

  if (SIGNED != 0) begin : g_sext
    assign w_ext = ACC_WIDTH'($signed(prod_q));
  end else begin : g_zext
    assign w_ext = ACC_WIDTH'(prod_q);
  end

  assign w_sum = {1'b0, q_q} + {1'b0, w_ext};

  // Signed: operands agree in sign but the sum does not; unsigned: carry-out.
  assign w_add_ovf = (SIGNED != 0)
                   ? ((q_q[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != q_q[ACC_WIDTH-1]))
                   : w_sum[ACC_WIDTH];

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (vld2_q) begin
      if (!mode2_q || clr2_q) begin
        q_d   = w_ext;
        ovf_d = 1'b0;
      end else begin
        q_d   = w_sum[ACC_WIDTH-1:0];
        ovf_d = ovf_q | w_add_ovf;
      end
    end else if (clr2_q) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      ovf_q       <= ovf_d;
      out_valid_q <= vld2_q;
    end
  end

  assign q         = q_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_acc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mult_acc_pipe: self-checking bench for three mult_acc_pipe variants      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mult_acc_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] a, b;
  logic       mode, acc_clr;

  logic        ov0, ov1, ov2;
  logic [23:0] q0;
  logic [15:0] q1;
  logic [23:0] q2;
  logic        of0, of1, of2;

  always #5 clk = ~clk;

  mult_acc_pipe #(.WIDTH(8), .ACC_WIDTH(24), .SIGNED(0)) u_u24 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .acc_clr(acc_clr), .out_valid(ov0), .q(q0), .overflow(of0));
  mult_acc_pipe #(.WIDTH(8), .ACC_WIDTH(16), .SIGNED(0)) u_u16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .acc_clr(acc_clr), .out_valid(ov1), .q(q1), .overflow(of1));
  mult_acc_pipe #(.WIDTH(8), .ACC_WIDTH(24), .SIGNED(1)) u_s24 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .acc_clr(acc_clr), .out_valid(ov2), .q(q2), .overflow(of2));

  typedef struct {
    bit       v;
    bit [7:0] a;
    bit [7:0] b;
    bit       m;
    bit       c;
  } smp_t;

  typedef struct {
    bit          v;
    bit [7:0]    a;
    bit [7:0]    b;
    bit          m;
    bit          c;
    bit          ev;
    int unsigned q24;
    int unsigned q16;
    bit          ov16;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Reference model: samples wait two edges in a queue, then update the
  // per-variant accumulator with plain integer arithmetic.
  smp_t   pipe[$];
  longint m_acc[3];
  bit     m_ov[3];
  bit     m_ev;
  int     aw[3] = '{24, 16, 24};
  bit     sg[3] = '{1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint sx8(input bit [7:0] x);
    return x[7] ? longint'(x) - 256 : longint'(x);
  endfunction

  function automatic void model_reset();
    smp_t idle;
    idle = '{1'b0, 8'd0, 8'd0, 1'b0, 1'b0};
    pipe.delete();
    pipe.push_back(idle);
    pipe.push_back(idle);
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0;
      m_ov[i]  = 1'b0;
    end
    m_ev = 1'b0;
  endfunction

  function automatic void mstep(input int i, input smp_t s);
    longint mask, half, p, e, sum, acc_s;
    bit     o;
    mask = (longint'(1) << aw[i]) - 1;
    half = longint'(1) << (aw[i] - 1);
    p    = sg[i] ? sx8(s.a) * sx8(s.b) : longint'(s.a) * longint'(s.b);
    e    = p & mask;
    if (s.v) begin
      if (!s.m || s.c) begin
        m_acc[i] = e;
        m_ov[i]  = 1'b0;
      end else begin
        if (!sg[i]) begin
          sum = m_acc[i] + e;
          o   = sum > mask;
        end else begin
          acc_s = (m_acc[i] >= half) ? m_acc[i] - (mask + 1) : m_acc[i];
          sum   = acc_s + p;
          o     = (sum >= half) || (sum < -half);
        end
        m_acc[i] = sum & mask;
        m_ov[i]  = m_ov[i] | o;
      end
    end else if (s.c) begin
      m_acc[i] = 0;
      m_ov[i]  = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    smp_t s, cur;
    cur  = '{in_valid, a, b, mode, acc_clr};
    s    = pipe.pop_front();
    m_ev = s.v;
    for (int i = 0; i < 3; i++) mstep(i, s);
    pipe.push_back(cur);
  endfunction

  task automatic model_check();
    chk("u24_out_valid", longint'(ov0), longint'(m_ev));
    chk("u16_out_valid", longint'(ov1), longint'(m_ev));
    chk("s24_out_valid", longint'(ov2), longint'(m_ev));
    chk("u24_q", longint'(q0), m_acc[0]);
    chk("u16_q", longint'(q1), m_acc[1]);
    chk("s24_q", longint'(q2), m_acc[2]);
    chk("u24_overflow", longint'(of0), longint'(m_ov[0]));
    chk("u16_overflow", longint'(of1), longint'(m_ov[1]));
    chk("s24_overflow", longint'(of2), longint'(m_ov[2]));
  endtask

  // Inputs are held across one rising edge; outputs are sampled 1ns later.
  task automatic apply(input bit v, input bit [7:0] ai, input bit [7:0] bi,
                       input bit m, input bit c);
    in_valid = v;
    a        = ai;
    b        = bi;
    mode     = m;
    acc_clr  = c;
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  vec_t tbl[22];

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    mode     = 1'b0;
    acc_clr  = 1'b0;
    model_reset();
    #1;
    model_check();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    //          v  a    b    m  c  ev  q24     q16    ov16
    tbl[0]  = '{1, 12,  10,  0, 0, 0,  0,      0,     0};
    tbl[1]  = '{0, 0,   0,   0, 0, 0,  0,      0,     0};
    tbl[2]  = '{0, 0,   0,   0, 0, 1,  120,    120,   0};
    tbl[3]  = '{1, 255, 255, 1, 1, 0,  120,    120,   0};
    tbl[4]  = '{1, 255, 255, 1, 0, 0,  120,    120,   0};
    tbl[5]  = '{1, 255, 255, 1, 0, 1,  65025,  65025, 0};
    tbl[6]  = '{0, 0,   0,   0, 0, 1,  130050, 64514, 1};
    tbl[7]  = '{0, 0,   0,   0, 0, 1,  195075, 64003, 1};
    tbl[8]  = '{0, 0,   0,   0, 0, 0,  195075, 64003, 1};
    tbl[9]  = '{1, 2,   3,   1, 1, 0,  195075, 64003, 1};
    tbl[10] = '{0, 0,   0,   0, 0, 0,  195075, 64003, 1};
    tbl[11] = '{0, 0,   0,   0, 0, 1,  6,      6,     0};
    tbl[12] = '{0, 0,   0,   0, 0, 0,  6,      6,     0};
    tbl[13] = '{0, 0,   0,   0, 0, 0,  6,      6,     0};
    tbl[14] = '{0, 0,   0,   0, 0, 0,  6,      6,     0};
    tbl[15] = '{1, 4,   5,   1, 0, 0,  6,      6,     0};
    tbl[16] = '{0, 0,   0,   0, 0, 0,  6,      6,     0};
    tbl[17] = '{0, 0,   0,   0, 0, 1,  26,     26,    0};
    tbl[18] = '{0, 0,   0,   0, 1, 0,  26,     26,    0};
    tbl[19] = '{0, 0,   0,   0, 0, 0,  26,     26,    0};
    tbl[20] = '{0, 0,   0,   0, 0, 0,  0,      0,     0};
    tbl[21] = '{0, 0,   0,   0, 0, 0,  0,      0,     0};

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].c);
      chk($sformatf("tbl%0d_out_valid", i), longint'(ov0), longint'(tbl[i].ev));
      chk($sformatf("tbl%0d_q24", i), longint'(q0), longint'(tbl[i].q24));
      chk($sformatf("tbl%0d_q16", i), longint'(q1), longint'(tbl[i].q16));
      chk($sformatf("tbl%0d_ovf16", i), longint'(of1), longint'(tbl[i].ov16));
    end

    // Signed variant: -3*5, then accumulate -128*-128
    apply(1'b1, 8'hFD, 8'd5, 1'b0, 1'b0);
    apply(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
    apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("signed_mul_q", longint'(q2), longint'(24'hFFFFF1));
    chk("signed_mul_out_valid", longint'(ov2), 1);
    apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("signed_acc_q", longint'(q2), 16369);
    chk("signed_acc_ovf", longint'(of2), 0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit [7:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 8'(8'hF0 | $urandom_range(0, 15)) : 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 8'(8'h80 | $urandom_range(0, 127)) : 8'($urandom);
      apply($urandom_range(0, 3) != 0, ra, rb,
            $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
    end

    // Asynchronous reset with three samples in flight
    apply(1'b1, 8'd7, 8'd9, 1'b0, 1'b0);
    apply(1'b1, 8'd3, 8'd3, 1'b1, 1'b0);
    apply(1'b1, 8'd5, 8'd5, 1'b1, 1'b0);
    chk("pre_reset_q", longint'(q0), 63);
    in_valid = 1'b1;
    a        = 8'd11;
    b        = 8'd13;
    mode     = 1'b1;
    acc_clr  = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", longint'(ov0), 0);
    chk("async_rst_q24", longint'(q0), 0);
    chk("async_rst_q16", longint'(q1), 0);
    chk("async_rst_qs", longint'(q2), 0);
    chk("async_rst_ovf", longint'(of1), 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    for (int n = 0; n < 5; n++) apply(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
